// File: rtl/ram_bus_master_if.sv
// Controller request/response handshake plus SRAM strobe-bus pins for ram_bus_master.
// master = the bus master itself; slave = the environment (controller + RAM) around it.
interface ram_bus_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_data_oe;
  logic [DATA_W-1:0] bus_data_i;
  logic              n_cs;
  logic              n_oe;
  logic              n_we;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, bus_data_i,
    output req_ready, done, rdata, busy, bus_addr, bus_data_o, bus_data_oe, n_cs, n_oe, n_we
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, bus_data_i,
    input  req_ready, done, rdata, busy, bus_addr, bus_data_o, bus_data_oe, n_cs, n_oe, n_we
  );
endinterface

// File: rtl/ram_bus_master.sv
// Async-SRAM strobe-bus initiator: one load/store at a time, timed SETUP/ACCESS/HOLD phases,
// read data returned with a one-cycle done pulse. All outputs registered.
module ram_bus_master #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  res,
  ram_bus_master_if.master      bus
);

  localparam int unsigned MAX_SA  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int unsigned MAX_CYC = (MAX_SA > HOLD_CYC) ? MAX_SA : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                data_oe_q, data_oe_d;
  logic                n_cs_q, n_cs_d;
  logic                n_oe_q, n_oe_d;
  logic                n_we_q, n_we_d;

  // Phase sequencing; strobes are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          // Sample the RAM while n_oe is still low on this edge.
          if (!we_q) rdata_d = bus.bus_data_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d   = (state_d == ST_IDLE);
    busy_d    = ~ready_d;
    n_cs_d    = ready_d;
    n_oe_d    = !((state_d == ST_ACCESS) && !we_d);
    n_we_d    = !((state_d == ST_ACCESS) && we_d);
    data_oe_d = !ready_d && we_d;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      data_oe_q <= 1'b0;
      n_cs_q    <= 1'b1;
      n_oe_q    <= 1'b1;
      n_we_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      data_oe_q <= data_oe_d;
      n_cs_q    <= n_cs_d;
      n_oe_q    <= n_oe_d;
      n_we_q    <= n_we_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_data_o  = wdata_q;
  assign bus.bus_data_oe = data_oe_q;
  assign bus.n_cs        = n_cs_q;
  assign bus.n_oe        = n_oe_q;
  assign bus.n_we        = n_we_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: three parameterisations share one stimulus stream, each with a RAM model,
// a scoreboard queue and per-cycle bus invariant checks; directed detail checks target instance 0.
module tb_ram_bus_master;

  localparam int unsigned NDUT = 3;
  localparam int unsigned S_CYC [NDUT] = '{1, 1, 2};
  localparam int unsigned A_CYC [NDUT] = '{2, 1, 3};
  localparam int unsigned H_CYC [NDUT] = '{1, 1, 2};

  typedef struct {
    logic        we;
    logic [7:0]  rdata;
    int unsigned acc;
  } exp_t;

  logic        clk;
  logic        res;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  int unsigned cyc;
  int unsigned n_pass;
  int unsigned n_fail;
  int unsigned n_total;
  bit          inv_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ram_bus_master_if bus ();
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    exp_t       exp_q   [$];
    exp_t       e;
    logic       prev_cs;
    logic [7:0] prev_addr;
    logic [7:0] last_rd;

    assign bus.req_valid  = req_valid;
    assign bus.req_we     = req_we;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.bus_data_i = (bus.n_cs === 1'b0 && bus.n_oe === 1'b0) ? mem[bus.bus_addr] : 8'h00;

    ram_bus_master #(
      .ADDR_W(8), .DATA_W(8),
      .SETUP_CYC(S_CYC[g]), .ACCESS_CYC(A_CYC[g]), .HOLD_CYC(H_CYC[g])
    ) u_dut (
      .clk(clk),
      .res(res),
      .bus(bus.master)
    );

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     = 8'h00;
        ref_mem[i] = 8'h00;
      end
      prev_cs = 1'b1;
      prev_addr = 8'h00;
      last_rd = 8'h00;
    end

    // RAM model: writes only with n_we low and n_oe high.
    always @(posedge clk)
      if (bus.n_cs === 1'b0 && bus.n_we === 1'b0 && bus.n_oe === 1'b1 && bus.bus_data_oe === 1'b1)
        mem[bus.bus_addr] <= bus.bus_data_o;

    always @(negedge clk) begin
      if (inv_en) begin
        check($sformatf("inv%0d_oe_we_both_low", g), 32'(bus.n_oe === 1'b0 && bus.n_we === 1'b0), 0);
        check($sformatf("inv%0d_drive_while_oe", g), 32'(bus.bus_data_oe === 1'b1 && bus.n_oe === 1'b0), 0);
        check($sformatf("inv%0d_strobe_wo_cs", g),
              32'((bus.n_oe === 1'b0 || bus.n_we === 1'b0) && bus.n_cs !== 1'b0), 0);
        if (prev_cs === 1'b0 && bus.n_cs === 1'b0)
          check($sformatf("inv%0d_addr_stable", g), 32'(bus.bus_addr), 32'(prev_addr));
      end
      prev_cs   = bus.n_cs;
      prev_addr = bus.bus_addr;

      if (res === 1'b1) begin
        exp_q.delete();
        last_rd = 8'h00;
      end else begin
        if (bus.done === 1'b1) begin
          check($sformatf("sb%0d_done_expected", g), 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("sb%0d_latency", g), cyc - e.acc, S_CYC[g] + A_CYC[g] + H_CYC[g]);
            if (!e.we) last_rd = e.rdata;
            check($sformatf("sb%0d_rdata", g), 32'(bus.rdata), 32'(last_rd));
          end
        end
        if (req_valid === 1'b1 && bus.req_ready === 1'b1) begin
          e.we  = req_we;
          e.acc = cyc + 1;
          if (req_we) begin
            ref_mem[req_addr] = req_wdata;
            e.rdata = 8'h00;
          end else begin
            e.rdata = ref_mem[req_addr];
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  function automatic bit all_idle();
    return g_dut[0].bus.req_ready === 1'b1 && g_dut[1].bus.req_ready === 1'b1 &&
           g_dut[2].bus.req_ready === 1'b1 && g_dut[0].exp_q.size() == 0 &&
           g_dut[1].exp_q.size() == 0 && g_dut[2].exp_q.size() == 0;
  endfunction

  task automatic wait_all_idle();
    int n = 0;
    while (!all_idle() && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(n < 100), 1);
  endtask

  // Issues one request to every instance and samples instance 0 during cycles 1..5 after acceptance.
  task automatic run_txn(input logic we, input logic [7:0] a, input logic [7:0] d,
                         output logic [5:1] cs, output logic [5:1] oe, output logic [5:1] wn,
                         output logic [5:1] doe, output logic [5:1] dn, output logic [7:0] rd);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cs[k]  = g_dut[0].bus.n_cs;
      oe[k]  = g_dut[0].bus.n_oe;
      wn[k]  = g_dut[0].bus.n_we;
      doe[k] = g_dut[0].bus.bus_data_oe;
      dn[k]  = g_dut[0].bus.done;
      rd     = g_dut[0].bus.rdata;
    end
  endtask

  initial begin
    logic [5:1]  cs, oe, wn, doe, dn;
    logic [7:0]  rd;
    int unsigned e0, rel;
    int          n;
    bit          seen_done;

    n_pass = 0; n_fail = 0; n_total = 0; inv_en = 1'b0;
    res = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hAA; req_wdata = 8'h55;

    // Reset with a pending request: reset must win.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_n_cs", g_dut[0].bus.n_cs, 1);
      check("rst_n_oe", g_dut[0].bus.n_oe, 1);
      check("rst_n_we", g_dut[0].bus.n_we, 1);
      check("rst_data_oe", g_dut[0].bus.bus_data_oe, 0);
      check("rst_req_ready", g_dut[0].bus.req_ready, 1);
    end
    check("rst_busy", g_dut[0].bus.busy, 0);
    check("rst_done", g_dut[0].bus.done, 0);
    check("rst_rdata", g_dut[0].bus.rdata, 0);
    check("rst_bus_addr", g_dut[0].bus.bus_addr, 0);
    check("rst_bus_data_o", g_dut[0].bus.bus_data_o, 0);
    res = 1'b0; req_valid = 1'b0;
    inv_en = 1'b1;
    @(posedge clk); #1;

    // Write 7D @ 4F.
    run_txn(1'b1, 8'h4F, 8'h7D, cs, oe, wn, doe, dn, rd);
    check("wr_n_cs", 32'(cs), 32'(5'b10000));
    check("wr_n_we", 32'(wn), 32'(5'b11001));
    check("wr_n_oe", 32'(oe), 32'(5'b11111));
    check("wr_data_oe", 32'(doe), 32'(5'b01111));
    check("wr_done", 32'(dn), 32'(5'b10000));
    check("wr_mem", g_dut[0].mem[8'h4F], 8'h7D);
    check("wr_rdata_untouched", rd, 8'h00);
    wait_all_idle();

    // Read it back.
    run_txn(1'b0, 8'h4F, 8'h00, cs, oe, wn, doe, dn, rd);
    check("rd_n_cs", 32'(cs), 32'(5'b10000));
    check("rd_n_oe", 32'(oe), 32'(5'b11001));
    check("rd_n_we", 32'(wn), 32'(5'b11111));
    check("rd_data_oe", 32'(doe), 32'(5'b00000));
    check("rd_done", 32'(dn), 32'(5'b10000));
    check("rd_rdata", rd, 8'h7D);
    wait_all_idle();

    // Back-to-back: request stays valid and changes to a read mid-write.
    req_we = 1'b1; req_addr = 8'h31; req_wdata = 8'h1F; req_valid = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    req_we = 1'b0; req_wdata = 8'hEE;
    n = 0;
    while (g_dut[0].bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_ready_at", cyc - e0, 4);
    check("b2b_done_with_ready", g_dut[0].bus.done, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_second_accept", g_dut[0].bus.busy, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (g_dut[0].bus.done !== 1'b1 && n < 20);
    check("b2b_done_at", cyc - e0, 9);
    check("b2b_rdata", g_dut[0].bus.rdata, 8'h1F);
    check("b2b_mem", g_dut[0].mem[8'h31], 8'h1F);
    wait_all_idle();

    // Abort a read during ACCESS.
    req_we = 1'b0; req_addr = 8'h4F; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_in_access", g_dut[0].bus.n_oe, 0);
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    check("abort_n_oe", g_dut[0].bus.n_oe, 1);
    check("abort_n_cs", g_dut[0].bus.n_cs, 1);
    check("abort_rdata", g_dut[0].bus.rdata, 0);
    check("abort_ready", g_dut[0].bus.req_ready, 1);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (g_dut[0].bus.done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 0);
    @(posedge clk); #1;

    run_txn(1'b0, 8'h4F, 8'h00, cs, oe, wn, doe, dn, rd);
    check("post_abort_done", 32'(dn), 32'(5'b10000));
    check("post_abort_rdata", rd, 8'h7D);
    wait_all_idle();

    check("sweep2_mem", g_dut[2].mem[8'h4F], 8'h7D);
    check("sweep1_rdata", g_dut[1].bus.rdata, 8'h7D);
    check("sweep2_rdata", g_dut[2].bus.rdata, 8'h7D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
